// File: rtl/ssd_pkg.sv
// Shared definitions for the two-digit seven-segment bus: segment patterns,
// digit codes, monitor FSM states and the frame evaluation rule.
package ssd_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned VAL_W = 8;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3f;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5b;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4f;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6d;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7d;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7f;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6f;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

    localparam logic [DIG_W-1:0] DIG_BLANK = 4'hA;
    localparam logic [DIG_W-1:0] DIG_DASH  = 4'hB;
    localparam logic [DIG_W-1:0] DIG_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_ALIGN  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic             out_of_range;
        logic             seg_error;
    } frame_t;

    // Turns a tens/units digit-code pair into the reported result.
    function automatic frame_t eval_frame(input logic [DIG_W-1:0] t, input logic [DIG_W-1:0] u);
        frame_t f;
        f = '0;
        if (t == DIG_DASH && u == DIG_DASH) begin
            f.value        = 8'hFF;
            f.out_of_range = 1'b1;
        end else if (u <= 4'd9 && t == DIG_BLANK) begin
            f.value = VAL_W'(u);
        end else if (u <= 4'd9 && t >= 4'd1 && t <= 4'd9) begin
            f.value = VAL_W'(t) * 8'd10 + VAL_W'(u);
        end else begin
            f.seg_error = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/ssd_digit_decode.sv
// Combinational segment-pattern to digit-code lookup.
module ssd_digit_decode
    import ssd_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [DIG_W-1:0] code
);

    always_comb begin
        code = DIG_BAD;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = DIG_BLANK;
            SEG_DASH:  code = DIG_DASH;
            default:   code = DIG_BAD;
        endcase
    end

endmodule

// File: rtl/ssd_decoder.sv
// Receive-side monitor for the multiplexed two-digit seven-segment bus:
// settles each digit phase, decodes the pair and strobes the value 0..99.
module ssd_decoder
    import ssd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] ssd_a,
    input  logic             ssd_c,
    output logic [VAL_W-1:0] value_out,
    output logic             value_valid,
    output logic             out_of_range,
    output logic             seg_error
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

    logic [SEG_W-1:0] a_meta, a_sync, a_prev;
    logic             c_meta, c_sync, c_prev;
    logic [CW-1:0]    cnt, cnt_next;
    logic [1:0]       warm;
    state_t           state, state_next;
    logic [DIG_W-1:0] tens_code;
    logic             tens_ok;
    logic [DIG_W-1:0] digit;
    logic             any_change, c_change, capture, frame_done;
    frame_t           frame;

    ssd_digit_decode u_decode (
        .seg  (a_sync),
        .code (digit)
    );

    // Two-flop synchronisers plus previous-cycle copies for change detection.
    // warm counts until the compare pipeline holds only post-reset samples,
    // so the synchroniser filling up is not mistaken for a phase change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_meta <= '0;
            a_sync <= '0;
            a_prev <= '0;
            c_meta <= 1'b0;
            c_sync <= 1'b0;
            c_prev <= 1'b0;
            warm   <= 2'd0;
        end else begin
            a_meta <= ssd_a;
            a_sync <= a_meta;
            a_prev <= a_sync;
            c_meta <= ssd_c;
            c_sync <= c_meta;
            c_prev <= c_sync;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign any_change = {c_sync, a_sync} != {c_prev, a_prev};
    assign c_change   = c_sync != c_prev;

    always_comb begin
        cnt_next = cnt;
        if (any_change) begin
            cnt_next = '0;
        end else if (cnt != CW'(SETTLE_CYCLES)) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_ALIGN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Phase FSM: capture fires on the SETTLE_CYCLES-th unchanged cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_ALIGN: begin
                if (warm == 2'd3 && c_change) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_next == CW'(SETTLE_CYCLES)) begin
                    capture    = 1'b1;
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (c_change) begin
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_ALIGN;
        endcase
    end

    assign frame_done = capture && !c_sync && tens_ok;
    assign frame      = eval_frame(tens_code, digit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_code <= DIG_BLANK;
            tens_ok   <= 1'b0;
        end else if (c_change && c_sync) begin
            tens_ok <= 1'b0;
        end else if (capture && c_sync) begin
            tens_code <= digit;
            tens_ok   <= 1'b1;
        end else if (frame_done) begin
            tens_ok <= 1'b0;
        end
    end

    // Result registers hold until the next completed frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_out    <= '0;
            value_valid  <= 1'b0;
            out_of_range <= 1'b0;
            seg_error    <= 1'b0;
        end else begin
            value_valid <= frame_done;
            if (frame_done) begin
                value_out    <= frame.value;
                out_of_range <= frame.out_of_range;
                seg_error    <= frame.seg_error;
            end
        end
    end

endmodule

// File: tb/tb_ssd_decoder.sv
// Bench for ssd_decoder: directed frame table, glitch and reset sequences,
// then randomized pairs checked against a rule-level reference model.
module tb_ssd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] ssd_a;
    logic       ssd_c;
    logic [7:0] value_out;
    logic       value_valid;
    logic       out_of_range;
    logic       seg_error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] v;
        logic       oor;
        logic       err;
    } res_t;

    typedef struct {
        string      name;
        logic [6:0] tens;
        logic [6:0] units;
        logic [7:0] v;
        logic       oor;
        logic       err;
    } vec_t;

    res_t got_q[$];

    ssd_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ssd_a        (ssd_a),
        .ssd_c        (ssd_c),
        .value_out    (value_out),
        .value_valid  (value_valid),
        .out_of_range (out_of_range),
        .seg_error    (seg_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && value_valid) begin
            got_q.push_back({value_out, out_of_range, seg_error});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold one bus phase for n cycles; called and returns at posedge+1.
    task automatic phase(input logic c, input logic [6:0] a, input int n);
        ssd_c = c;
        ssd_a = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string name, input bit exp_strobe, input res_t exp);
        res_t g;
        check({name, " strobes"}, 32'(got_q.size()), exp_strobe ? 32'd1 : 32'd0);
        if (exp_strobe && got_q.size() > 0) begin
            g = got_q.pop_front();
            check({name, " value"}, 32'(g.v), 32'(exp.v));
            check({name, " oor"},   32'(g.oor), 32'(exp.oor));
            check({name, " err"},   32'(g.err), 32'(exp.err));
        end
        got_q.delete();
    endtask

    // Reference model: segment pattern -> digit, then the frame rules.
    function automatic int seg_digit(input logic [6:0] s);
        logic [6:0] tbl [10];
        tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i] == s) return i;
        end
        if (s == 7'h00) return 10;
        if (s == 7'h40) return 11;
        return -1;
    endfunction

    function automatic res_t model(input logic [6:0] ts, input logic [6:0] us);
        int t, u;
        res_t r;
        t = seg_digit(ts);
        u = seg_digit(us);
        r = '0;
        if (t == 11 && u == 11) begin
            r.v = 8'hFF;
            r.oor = 1'b1;
        end else if (u >= 0 && u <= 9 && t == 10) begin
            r.v = 8'(u);
        end else if (u >= 0 && u <= 9 && t >= 1 && t <= 9) begin
            r.v = 8'(10 * t + u);
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] rand_seg();
        logic [6:0] tbl [12];
        int r;
        tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f, 7'h00, 7'h40};
        r = int'($urandom_range(0, 15));
        if (r < 12) return tbl[r];
        return 7'($urandom_range(0, 127));
    endfunction

    vec_t vecs[9];

    initial begin
        res_t exp;
        int   tlen;
        logic [6:0] t, u;

        vecs[0] = '{"v42",      7'h66, 7'h5b, 8'd42,  1'b0, 1'b0};
        vecs[1] = '{"v7",       7'h00, 7'h07, 8'd7,   1'b0, 1'b0};
        vecs[2] = '{"v99",      7'h6f, 7'h6f, 8'd99,  1'b0, 1'b0};
        vecs[3] = '{"dashdash", 7'h40, 7'h40, 8'hFF,  1'b1, 1'b0};
        vecs[4] = '{"bad_u",    7'h06, 7'h12, 8'h00,  1'b0, 1'b1};
        vecs[5] = '{"lead0",    7'h3f, 7'h06, 8'h00,  1'b0, 1'b1};
        vecs[6] = '{"dash_1",   7'h40, 7'h06, 8'h00,  1'b0, 1'b1};
        vecs[7] = '{"v0",       7'h00, 7'h3f, 8'd0,   1'b0, 1'b0};
        vecs[8] = '{"u_blank",  7'h4f, 7'h00, 8'h00,  1'b0, 1'b1};

        reset = 1'b1;
        ssd_c = 1'b0;
        ssd_a = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst value", 32'(value_out), 32'd0);
        check("rst valid", 32'(value_valid), 32'd0);
        check("rst oor",   32'(out_of_range), 32'd0);
        check("rst err",   32'(seg_error), 32'd0);
        reset = 1'b0;

        phase(1'b0, 7'h00, 10);
        got_q.delete();

        foreach (vecs[i]) begin
            phase(1'b1, vecs[i].tens, 16);
            phase(1'b0, vecs[i].units, 16);
            check_pair(vecs[i].name, 1'b1, {vecs[i].v, vecs[i].oor, vecs[i].err});
        end

        // Outputs hold between strobes.
        phase(1'b1, 7'h66, 6);
        check("hold value", 32'(value_out), 32'd0);
        check("hold err",   32'(seg_error), 32'd1);
        phase(1'b1, 7'h66, 10);
        phase(1'b0, 7'h5b, 16);
        check_pair("v42b", 1'b1, {8'd42, 1'b0, 1'b0});

        // Short tens phase: the following units phase is discarded.
        phase(1'b1, 7'h7f, 3);
        phase(1'b0, 7'h06, 16);
        check_pair("glitch", 1'b0, '0);
        phase(1'b1, 7'h6d, 16);
        phase(1'b0, 7'h7d, 16);
        check_pair("after_glitch", 1'b1, {8'd56, 1'b0, 1'b0});

        // Reset mid-settle in a tens phase.
        phase(1'b1, 7'h6f, 2);
        reset = 1'b1;
        #1;
        check("mid rst value", 32'(value_out), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid rst valid", 32'(value_valid), 32'd0);
        check("mid rst oor",   32'(out_of_range), 32'd0);
        check("mid rst err",   32'(seg_error), 32'd0);
        reset = 1'b0;
        phase(1'b1, 7'h6f, 12);
        phase(1'b0, 7'h06, 16);
        check_pair("post_rst_partial", 1'b0, '0);
        phase(1'b1, 7'h5b, 16);
        phase(1'b0, 7'h4f, 16);
        check_pair("post_rst_full", 1'b1, {8'd23, 1'b0, 1'b0});

        // Randomized pairs, with occasional short tens phases and segment
        // noise after the units digit has been captured.
        for (int k = 0; k < 60; k++) begin
            t = rand_seg();
            u = rand_seg();
            tlen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(6, 20));
            phase(1'b1, t, tlen);
            phase(1'b0, u, 12);
            phase(1'b0, 7'($urandom_range(0, 127)), 4);
            exp = model(t, u);
            check_pair($sformatf("rand%0d", k), tlen >= 6, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_decoder.md
# ssd_decoder

Receive-side monitor for the two-digit multiplexed seven-segment bus produced by the SSD driver. Samples the segment lines `ssd_a` and the digit-select line `ssd_c`, waits for each digit phase to settle, decodes both digits and reconstructs the 8-bit value 0..99. Flags out-of-range (dash-dash) and malformed frames. Used for on-board loopback self-check and as a bench checker on the display path.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive stable cycles required before a digit is captured; legal range 1..255.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `ssd_a` input 7: segment lines, bit 0 = segment a … bit 6 = segment g, active-high.
- `ssd_c` input 1: digit select; 1 = tens digit phase, 0 = units digit phase.
- `value_out` output 8: last decoded value, registered.
- `value_valid` output 1: one-cycle strobe; `value_out` and the flags are valid in this cycle.
- `out_of_range` output 1: registered; set with a strobe when the frame was dash-dash.
- `seg_error` output 1: registered; set with a strobe when the frame was malformed.

## Operation
- Segment codes: 0=3f, 1=06, 2=5b, 3=4f, 4=66, 5=6d, 6=7d, 7=07, 8=7f, 9=6f, BLANK=00, DASH=40. Any other pattern is BAD.
- `ssd_a` and `ssd_c` each pass through a 2-flop synchroniser; all logic below uses the synchronised copies.
- Stability counter: cleared when synchronised `{ssd_c, ssd_a}` differs from its previous-cycle value, otherwise incremented, saturating at `SETTLE_CYCLES`. Width is clog2(SETTLE_CYCLES+1).
- Phase FSM:
  - ALIGN: entered at reset. Leaves to SETTLE on the first change of synchronised `ssd_c`, so a partial first phase is never captured.
  - SETTLE: on the cycle the counter reaches `SETTLE_CYCLES`, capture the decoded digit and go to HELD. A `ssd_c` change restarts the settle window and stays in SETTLE.
  - HELD: ignores `ssd_a`. A `ssd_a` change does not re-capture. A `ssd_c` change goes to SETTLE.
- Tens capture: stores the tens code and sets `tens_ok`. Entering any tens phase clears `tens_ok`.
- Units capture with `tens_ok`=1 completes a frame and clears `tens_ok`. Units capture with `tens_ok`=0 is discarded silently (no strobe).
- Frame evaluation, from tens code T and units code U:
  - T=BLANK, U=0..9: value = U.
  - T=1..9, U=0..9: value = 10·T+U, computed in 8 bits; the maximum is 99, so no overflow.
  - T=DASH, U=DASH: value=8'hFF, `out_of_range`=1.
  - Anything else is an error: BAD, T=0 (leading zero), U=BLANK, or DASH paired with a non-dash. Result: value=8'h00, `seg_error`=1.
- `value_out`, `out_of_range` and `seg_error` hold until the next strobe.
- Reset asserted at any time (mid-settle or mid-frame): FSM returns to ALIGN, counter and `tens_ok` are cleared, all outputs go to 0.

## Timing
- Reset values: `value_out`=8'h00, `value_valid`=0, `out_of_range`=0, `seg_error`=0.
- Input-to-logic latency: 2 cycles (synchroniser).
- Capture happens on the `SETTLE_CYCLES`-th consecutive unchanged synchronised cycle.
- `value_valid` rises on the cycle after the units capture and stays high for exactly 1 cycle. Outputs update in that same cycle.
- Worst-case latency from the raw `ssd_c` falling edge to the strobe: 2 + `SETTLE_CYCLES` + 1 cycles.
- A phase shorter than `SETTLE_CYCLES` synchronised cycles yields no capture.
  - Short tens phase: `tens_ok` stays 0, so the next units capture is discarded.
- At most one strobe per tens/units pair. No back-pressure; consumers must sample on the strobe.

## Structure
- Shared package `ssd_pkg`:
  - the twelve segment constants;
  - 4-bit digit codes: 0..9, BLANK=4'hA, DASH=4'hB, BAD=4'hF;
  - FSM state encodings ALIGN/SETTLE/HELD.
- The SSD driver uses the same segment constants from `ssd_pkg`.
- One sub-module, `ssd_digit_decode`: combinational, 7-bit segment pattern in, 4-bit digit code out.
- Synchroniser, counter, FSM and frame evaluation stay in `ssd_decoder`.

## Test plan
All scenarios use `SETTLE_CYCLES`=4 and a `ssd_c` half-period of 16 cycles unless stated.
- Value 42: tens phase `ssd_a`=66, units phase `ssd_a`=5b → one strobe per pair, `value_out`=8'd42, flags 0.
- Value 7: tens 00, units 07 → `value_out`=8'd7. Then value 99: tens 6f, units 6f → `value_out`=8'd99.
- Out of range: tens 40, units 40 → `value_out`=8'hFF, `out_of_range`=1, `seg_error`=0.
- Malformed frames, each expecting one strobe with `seg_error`=1 and `value_out`=8'h00:
  - units 12 (BAD);
  - tens 3f (leading zero);
  - tens 40 with units 06.
- Glitch: a tens phase lasting 3 cycles, then a normal units phase → no strobe. The next full pair decodes correctly.
- Reset mid-settle during a tens phase:
  - all outputs read 0 while reset is asserted;
  - after release, the first partial phase is ignored (ALIGN);
  - the first strobe comes only after a complete tens+units pair.
